multicycle_param_processor: RTL and testbench



---
 rtl/multicycle_param_processor.sv | 178 +++++++++++++++++
 tb/tb_multicycle_param_processor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_param_processor.sv
// Parametrised multi-cycle core: FETCH/DECODE/EXECUTE/WRITEBACK over a fetch handshake.
// Optional build macro PROC_ZERO_REG_EN makes r0 read as zero and discards writes to it.
module multicycle_param_processor #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NREG   = 4,
   parameter int unsigned PC_W   = 4,
   localparam int unsigned RA    = $clog2(NREG),
   localparam int unsigned IW    = 3 + 3 * RA
) (
   input  logic              clk,
   input  logic              reset,
   output logic              fetch_req,
   output logic [PC_W-1:0]   fetch_addr,
   input  logic [IW-1:0]     instr,
   input  logic              instr_valid,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StHalt
   } state_e;

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpLi   = 3'b101;
   localparam logic [2:0] OpBnz  = 3'b110;
   localparam logic [2:0] OpHalt = 3'b111;

   state_e              state_q;
   logic [PC_W-1:0]     pc_q;
   logic [IW-1:0]       ir_q;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [DATA_W-1:0]   op_a_q, op_b_q;
   logic [DATA_W-1:0]   alu_q;
   logic                take_q;
   logic                fetch_req_q;
   logic [DATA_W-1:0]   result_q;
   logic                zero_q;
   logic                retire_q;
   logic                halted_q;

   logic [2:0]          opcode;
   logic [RA-1:0]       rd, rs1, rs2;
   logic [DATA_W-1:0]   rs1_val, rs2_val;
   logic [DATA_W-1:0]   imm_ext;
   logic [PC_W-1:0]     br_target;
   logic [DATA_W-1:0]   alu_d;
   logic                wr_en;

   assign opcode = ir_q[IW-1 -: 3];
   assign rd     = ir_q[3*RA-1 -: RA];
   assign rs2    = ir_q[2*RA-1 -: RA];
   assign rs1    = ir_q[RA-1:0];

   // Immediate and branch target are zero-extended or truncated to their destination widths.
   always_comb begin
      imm_ext   = '0;
      br_target = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (i < 2 * int'(RA)) imm_ext[i] = ir_q[i];
      end
      for (int i = 0; i < int'(PC_W); i++) begin
         if (i < 2 * int'(RA)) br_target[i] = ir_q[int'(RA) + i];
      end
   end

   always_comb begin
      rs1_val = regs_q[rs1];
      rs2_val = regs_q[rs2];
`ifdef PROC_ZERO_REG_EN
      if (rs1 == '0) rs1_val = '0;
      if (rs2 == '0) rs2_val = '0;
`endif
   end

   always_comb begin
      alu_d = '0;
      case (opcode)
         OpAdd:   alu_d = op_a_q + op_b_q;
         OpSub:   alu_d = op_a_q - op_b_q;
         OpAnd:   alu_d = op_a_q & op_b_q;
         OpOr:    alu_d = op_a_q | op_b_q;
         OpXor:   alu_d = op_a_q ^ op_b_q;
         OpLi:    alu_d = imm_ext;
         default: alu_d = '0;
      endcase
   end

   always_comb begin
      wr_en = (opcode != OpBnz) && (opcode != OpHalt);
`ifdef PROC_ZERO_REG_EN
      if (rd == '0) wr_en = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StFetch;
         pc_q        <= '0;
         ir_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         alu_q       <= '0;
         take_q      <= 1'b0;
         fetch_req_q <= 1'b1;
         result_q    <= '0;
         zero_q      <= 1'b1;
         retire_q    <= 1'b0;
         halted_q    <= 1'b0;
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            StFetch: begin
               if (instr_valid) begin
                  ir_q        <= instr;
                  fetch_req_q <= 1'b0;
                  state_q     <= StDecode;
               end
            end
            StDecode: begin
               op_a_q  <= rs1_val;
               op_b_q  <= rs2_val;
               state_q <= StExecute;
            end
            StExecute: begin
               if (opcode == OpHalt) begin
                  halted_q <= 1'b1;
                  state_q  <= StHalt;
               end else begin
                  alu_q   <= alu_d;
                  take_q  <= (opcode == OpBnz) && (op_a_q != '0);
                  state_q <= StWriteback;
               end
            end
            StWriteback: begin
               if (opcode != OpBnz) begin
                  result_q <= alu_q;
                  zero_q   <= (alu_q == '0);
               end
               if (wr_en) regs_q[rd] <= alu_q;
               pc_q        <= take_q ? br_target : pc_q + PC_W'(1);
               retire_q    <= 1'b1;
               fetch_req_q <= 1'b1;
               state_q     <= StFetch;
            end
            StHalt: ;
            default: state_q <= StFetch;
         endcase
      end
   end

   // The registered request is masked while reset is held so it never shows during reset.
   assign fetch_req  = fetch_req_q & ~reset;
   assign fetch_addr = pc_q;
   assign result     = result_q;
   assign zero       = zero_q;
   assign retire     = retire_q;
   assign halted     = halted_q;

`ifndef SYNTHESIS
   a_req_only_in_fetch : assert property (@(posedge clk) disable iff (reset)
      fetch_req |-> (state_q == StFetch));
   a_retire_single : assert property (@(posedge clk) disable iff (reset)
      retire |=> !retire);
`endif

endmodule

// File: tb/tb_multicycle_param_processor.sv
// Directed self-checking bench for multicycle_param_processor with a behavioural instruction memory.
module tb_multicycle_param_processor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       instr_valid = 1'b1;
   logic [8:0] instr;
   logic       fetch_req;
   logic [3:0] fetch_addr;
   logic [7:0] result;
   logic       zero, retire, halted;

   logic [8:0] imem [16];
   int vectors = 0;
   int miscompares = 0;

   assign instr = imem[fetch_addr];

   multicycle_param_processor #(.DATA_W(8), .NREG(4), .PC_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
      .result      (result),
      .zero        (zero),
      .retire      (retire),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) imem[i] = 9'h1C0;
   endtask

   task automatic apply_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   // Returns limit+1 in cycles if retire never appears.
   task automatic wait_retire(input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!retire && cycles <= limit);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_mem();
      @(negedge clk);
      @(negedge clk);
      vectors++; if (fetch_req !== 1'b0) begin miscompares++; $display("FAIL rst_fetch_req: got %b want 0", fetch_req); end
      vectors++; if (fetch_addr !== 4'h0) begin miscompares++; $display("FAIL rst_fetch_addr: got %h want 0", fetch_addr); end
      vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL rst_result: got %h want 00", result); end
      vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL rst_zero: got %b want 1", zero); end
      vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL rst_retire: got %b want 0", retire); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
      reset = 1'b0;
      #1;
      vectors++; if (fetch_req !== 1'b1) begin miscompares++; $display("FAIL rst_release_req: got %b want 1", fetch_req); end
   endtask

   task automatic test_add();
      int c;
      int hc;
      clear_mem();
      imem[0] = 9'h155; // LI r1,5
      imem[1] = 9'h163; // LI r2,3
      imem[2] = 9'h036; // ADD r3,r2,r1
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         wait_retire(20, c);
         vectors++; if (c !== 4) begin miscompares++; $display("FAIL add_retire_gap%0d: got %0d want 4", k, c); end
      end
      vectors++; if (result !== 8'h08) begin miscompares++; $display("FAIL add_result: got %h want 08", result); end
      vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b want 0", zero); end
      hc = 0;
      while (!halted && hc < 20) begin
         @(negedge clk);
         hc++;
      end
      vectors++; if (hc !== 3) begin miscompares++; $display("FAIL add_halt_latency: got %0d want 3", hc); end
      vectors++; if (fetch_addr !== 4'h3) begin miscompares++; $display("FAIL add_halt_addr: got %h want 3", fetch_addr); end
   endtask

   task automatic test_sub_xor();
      int c;
      clear_mem();
      imem[0] = 9'h153; // LI r1,3
      imem[1] = 9'h165; // LI r2,5
      imem[2] = 9'h079; // SUB r3,r1,r2
      imem[3] = 9'h13F; // XOR r3,r3,r3
      apply_reset();
      wait_retire(20, c);
      wait_retire(20, c);
      wait_retire(20, c);
      vectors++; if (result !== 8'hFE) begin miscompares++; $display("FAIL sub_result: got %h want fe", result); end
      vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL sub_zero: got %b want 0", zero); end
      wait_retire(20, c);
      vectors++; if (c !== 4) begin miscompares++; $display("FAIL xor_gap: got %0d want 4", c); end
      vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL xor_result: got %h want 00", result); end
      vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL xor_zero: got %b want 1", zero); end
   endtask

   task automatic test_branch_loop();
      int c;
      int extra;
      logic [7:0] exp_res [6];
      logic [3:0] exp_addr [6];
      logic       exp_zero [6];
      exp_res  = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00};
      exp_addr = '{4'h1, 4'h2, 4'h3, 4'h2, 4'h3, 4'h4};
      exp_zero = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      clear_mem();
      imem[0] = 9'h161; // LI r2,1
      imem[1] = 9'h152; // LI r1,2
      imem[2] = 9'h059; // SUB r1,r1,r2
      imem[3] = 9'h189; // BNZ r1 -> 2
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         wait_retire(20, c);
         vectors++; if (c !== 4) begin miscompares++; $display("FAIL br_gap%0d: got %0d want 4", k, c); end
         vectors++; if (result !== exp_res[k]) begin miscompares++; $display("FAIL br_result%0d: got %h want %h", k, result, exp_res[k]); end
         vectors++; if (zero !== exp_zero[k]) begin miscompares++; $display("FAIL br_zero%0d: got %b want %b", k, zero, exp_zero[k]); end
         vectors++; if (fetch_addr !== exp_addr[k]) begin miscompares++; $display("FAIL br_addr%0d: got %h want %h", k, fetch_addr, exp_addr[k]); end
      end
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (retire) extra++;
      end
      vectors++; if (extra !== 0) begin miscompares++; $display("FAIL br_retire_after_halt: got %0d want 0", extra); end
      vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL br_halted: got %b want 1", halted); end
      vectors++; if (fetch_addr !== 4'h4) begin miscompares++; $display("FAIL br_halt_addr: got %h want 4", fetch_addr); end
      vectors++; if (fetch_req !== 1'b0) begin miscompares++; $display("FAIL br_halt_req: got %b want 0", fetch_req); end
   endtask

   task automatic test_fetch_stall();
      int c;
      clear_mem();
      imem[0] = 9'h155; // LI r1,5
      instr_valid = 1'b0;
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++; if (fetch_req !== 1'b1) begin miscompares++; $display("FAIL stall_req%0d: got %b want 1", k, fetch_req); end
      end
      instr_valid = 1'b1;
      wait_retire(20, c);
      vectors++; if (c + 3 !== 7) begin miscompares++; $display("FAIL stall_first_retire: got %0d want 7", c + 3); end
      vectors++; if (result !== 8'h05) begin miscompares++; $display("FAIL stall_result: got %h want 05", result); end
   endtask

   task automatic test_reset_in_writeback();
      int c;
      clear_mem();
      imem[0] = 9'h157; // LI r1,7
      apply_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++; if (fetch_req !== 1'b0) begin miscompares++; $display("FAIL wbrst_req: got %b want 0", fetch_req); end
      vectors++; if (fetch_addr !== 4'h0) begin miscompares++; $display("FAIL wbrst_pc: got %h want 0", fetch_addr); end
      vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL wbrst_result: got %h want 00", result); end
      vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL wbrst_retire: got %b want 0", retire); end
      imem[0] = 9'h025; // ADD r2,r1,r1 exposes r1
      reset = 1'b0;
      #1;
      vectors++; if (fetch_req !== 1'b1) begin miscompares++; $display("FAIL wbrst_req_after: got %b want 1", fetch_req); end
      wait_retire(20, c);
      vectors++; if (c !== 4) begin miscompares++; $display("FAIL wbrst_gap: got %0d want 4", c); end
      vectors++; if (result !== 8'h00) begin miscompares++; $display("FAIL wbrst_r1_clear: got %h want 00", result); end
      vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL wbrst_zero: got %b want 1", zero); end
   endtask

   task automatic test_pc_wrap();
      int c;
      clear_mem();
      imem[0]  = 9'h151; // LI r1,1
      imem[1]  = 9'h1BD; // BNZ r1 -> 15
      imem[15] = 9'h166; // LI r2,6
      apply_reset();
      wait_retire(20, c);
      wait_retire(20, c);
      vectors++; if (fetch_addr !== 4'hF) begin miscompares++; $display("FAIL wrap_target: got %h want f", fetch_addr); end
      vectors++; if (result !== 8'h01) begin miscompares++; $display("FAIL wrap_bnz_result: got %h want 01", result); end
      wait_retire(20, c);
      vectors++; if (fetch_addr !== 4'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", fetch_addr); end
      vectors++; if (result !== 8'h06) begin miscompares++; $display("FAIL wrap_result: got %h want 06", result); end
   endtask

   task automatic test_zero_reg();
      int c;
      logic [7:0] exp_add;
      logic       exp_z;
`ifdef PROC_ZERO_REG_EN
      exp_add = 8'h00;
      exp_z   = 1'b1;
`else
      exp_add = 8'h12;
      exp_z   = 1'b0;
`endif
      clear_mem();
      imem[0] = 9'h149; // LI r0,9
      imem[1] = 9'h010; // ADD r1,r0,r0
      apply_reset();
      wait_retire(20, c);
      vectors++; if (result !== 8'h09) begin miscompares++; $display("FAIL zr_li_result: got %h want 09", result); end
      wait_retire(20, c);
      vectors++; if (result !== exp_add) begin miscompares++; $display("FAIL zr_add_result: got %h want %h", result, exp_add); end
      vectors++; if (zero !== exp_z) begin miscompares++; $display("FAIL zr_add_zero: got %b want %b", zero, exp_z); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_xor();
      test_branch_loop();
      test_fetch_stall();
      test_reset_in_writeback();
      test_pc_wrap();
      test_zero_reg();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
